load_store_unit: RTL and testbench

//   Memory stage directly downstream of the ALU. Takes the ALU result (Y) as the effective address of a load/store.

---
 rtl/load_store_unit_if.sv | 27 ++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and data memory.
//   mem_req    master->slave  request, held until mem_ready
//   mem_we     master->slave  1 = write
//   mem_addr   master->slave  word-aligned address
//   mem_wstrb  master->slave  byte enables (0000 for reads)
//   mem_wdata  master->slave  lane-replicated write data
//   mem_rdata  slave->master  read word, valid with mem_ready
//   mem_ready  slave->master  completes the current request
interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: memory stage fed by the ALU result as effective address.
// Validates the access, runs one req/ready transaction on the memory bus and
// returns the aligned, extended load value with a one-cycle lsu_done pulse.
//   clk, rst      clock; synchronous active-high reset
//   lsu_valid     memory instruction present, held until lsu_done
//   lsu_load/store operation select (both set is rejected)
//   lsu_funct3    RV32I width/sign encoding
//   lsu_addr      effective address
//   lsu_wdata     store data
//   lsu_rdata     extended load result, valid with lsu_done
//   lsu_done      completion pulse
//   lsu_err       with lsu_done: misaligned / illegal / timeout
//   lsu_stall     combinational hold request to the core
//   mem           memory bus (master side)
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16  // BUSY cycles without ready before error; 0 disables
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lsu_valid,
  input  logic                     lsu_load,
  input  logic                     lsu_store,
  input  logic [2:0]               lsu_funct3,
  input  logic [31:0]              lsu_addr,
  input  logic [31:0]              lsu_wdata,
  output logic [31:0]              lsu_rdata,
  output logic                     lsu_done,
  output logic                     lsu_err,
  output logic                     lsu_stall,
  load_store_unit_if.master        mem
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam bit         HAS_TIMEOUT = (TIMEOUT != 0);
  localparam logic [7:0] CNT_LAST    = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        reject;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] ld_ext;

  assign lsu_stall = lsu_valid & (lsu_load | lsu_store) & ~lsu_done;

  // Request decode on the live inputs; only consumed in IDLE.
  // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    reject  = 1'b0;
    st_strb = 4'b1111;
    st_data = lsu_wdata;
    if (lsu_load && lsu_store)
      reject = 1'b1;
    else if (lsu_load)
      reject = !(lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else
      reject = !(lsu_funct3 inside {3'b000, 3'b001, 3'b010});
    // funct3[1:0] is the access size; the illegal encodings are already rejected above.
    unique case (lsu_funct3[1:0])
      2'b00: begin
        st_strb = 4'b0001 << lsu_addr[1:0];
        st_data = {4{lsu_wdata[7:0]}};
      end
      2'b01: begin
        if (lsu_addr[0]) reject = 1'b1;
        st_strb = lsu_addr[1] ? 4'b1100 : 4'b0011;
        st_data = {2{lsu_wdata[15:0]}};
      end
      default: begin
        if (lsu_addr[1:0] != 2'b00) reject = 1'b1;
      end
    endcase
  end

  // Load extraction from the returned word using the latched offset/width.
  always_comb begin
    rd_shift = mem.mem_rdata >> {off_q, 3'b000};
    rd_half  = off_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    unique case (funct3_q)
      3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
      3'b101:  ld_ext = {16'h0, rd_half};
      default: ld_ext = mem.mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      load_q        <= 1'b0;
      funct3_q      <= '0;
      off_q         <= '0;
      lsu_rdata     <= '0;
      lsu_done      <= 1'b0;
      lsu_err       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wstrb <= '0;
      mem.mem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (lsu_valid && (lsu_load || lsu_store)) begin
            load_q   <= lsu_load && !lsu_store;
            funct3_q <= lsu_funct3;
            off_q    <= lsu_addr[1:0];
            if (reject) begin
              state    <= RESP;
              lsu_done <= 1'b1;
              lsu_err  <= 1'b1;
            end else begin
              state         <= BUSY;
              cnt           <= '0;
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= lsu_store;
              mem.mem_addr  <= {lsu_addr[31:2], 2'b00};
              mem.mem_wstrb <= lsu_store ? st_strb : 4'b0000;
              mem.mem_wdata <= lsu_store ? st_data : 32'h0;
            end
          end
        end
        BUSY: begin
          // Ready has priority over the timeout in the same cycle.
          if (mem.mem_ready) begin
            state       <= RESP;
            mem.mem_req <= 1'b0;
            lsu_done    <= 1'b1;
            lsu_err     <= 1'b0;
            lsu_rdata   <= load_q ? ld_ext : 32'h0;
          end else if (HAS_TIMEOUT && cnt == CNT_LAST) begin
            state       <= RESP;
            mem.mem_req <= 1'b0;
            lsu_done    <= 1'b1;
            lsu_err     <= 1'b1;
            lsu_rdata   <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin  // RESP
          state     <= IDLE;
          lsu_done  <= 1'b0;
          lsu_err   <= 1'b0;
          lsu_rdata <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit (TIMEOUT = 4). The bench plays both
// the core and the memory, drives each access open-loop by cycle index, and a
// compare process checks the DUT every cycle against an access-level model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_load, lsu_store;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic        lsu_done, lsu_err, lsu_stall;

  load_store_unit_if mif ();

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_load(lsu_load), .lsu_store(lsu_store),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_rdata(lsu_rdata), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .lsu_stall(lsu_stall), .mem(mif.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- access-level model ----------------
  function automatic int op_size(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit op_ok(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
    if (ld && st) return 1'b0;
    if (st && f3 > 3'd2) return 1'b0;
    if (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
    return (int'(a[1:0]) % op_size(f3)) == 0;
  endfunction

  // Bytes off..off+n-1 of the word, little-endian, then sign- or zero-extended.
  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
    int n = op_size(f3);
    int off = int'(a[1:0]);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v |= ((w >> (8 * (off + i))) & 32'hFF) << (8 * i);
    if (!f3[2] && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  // Lanes off..off+n-1 enabled; every lane carries data byte (lane mod n).
  function automatic void model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                                      output logic [3:0] strb, output logic [31:0] wd);
    int n = op_size(f3);
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      strb[i] = (i >= off) && (i < off + n);
      wd[8 * i +: 8] = d[8 * (i % n) +: 8];
    end
  endfunction

  // ---------------- expectations shared with the compare process ----------------
  bit          chk_en = 1'b0;
  bit          exp_req, exp_done, exp_err, exp_stall, exp_we;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  int          cur_k;
  // Observations of the DUT, pinned against hand-computed literals.
  logic [31:0] got_rdata, got_addr, got_wdata;
  logic [3:0]  got_wstrb;
  logic        got_we, got_err;
  int          got_done_k, req_cycles;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(lsu_stall), 32'(exp_stall));
      check("done", 32'(lsu_done), 32'(exp_done));
      check("mem_req", 32'(mif.mem_req), 32'(exp_req));
      if (exp_req) begin
        check("mem_we", 32'(mif.mem_we), 32'(exp_we));
        check("mem_addr", mif.mem_addr, exp_addr);
        check("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_wstrb));
        if (exp_we) check("mem_wdata", mif.mem_wdata, exp_wdata);
      end
      if (exp_done) begin
        check("err", 32'(lsu_err), 32'(exp_err));
        check("rdata", lsu_rdata, exp_rdata);
      end
      if (mif.mem_req === 1'b1) begin
        req_cycles++;
        got_addr  = mif.mem_addr;
        got_we    = mif.mem_we;
        got_wstrb = mif.mem_wstrb;
        got_wdata = mif.mem_wdata;
      end
      if (lsu_done === 1'b1) begin
        got_done_k = cur_k;
        got_rdata  = lsu_rdata;
        got_err    = lsu_err;
      end
    end
  end

  // One access: w = wait cycles before ready (ready on BUSY cycle w+1);
  // abort_at >= 0 pulses rst during that cycle and returns with lsu_valid held.
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] rd, input int w, input int abort_at);
    bit ok = op_ok(ld, st, f3, a);
    bit to = ok && (w >= TO);
    int busy = !ok ? 0 : (to ? TO : w + 1);
    int dk = busy + 1;
    int last = (abort_at >= 0) ? abort_at : dk + 1;
    logic [3:0]  s_strb;
    logic [31:0] s_wd;
    model_store(f3, a, d, s_strb, s_wd);
    req_cycles = 0; got_done_k = -1; got_rdata = 32'hx; got_err = 1'bx;
    for (int k = 0; k <= last; k++) begin
      cur_k = k;
      lsu_valid = (k <= dk);
      lsu_load  = (k <= dk) ? ld : 1'b0;
      lsu_store = (k <= dk) ? st : 1'b0;
      if (k == 0) begin
        lsu_funct3 = f3; lsu_addr = a; lsu_wdata = d;
      end else begin
        // Inputs other than valid/op wander once the access is latched.
        lsu_funct3 = 3'($urandom); lsu_addr = $urandom; lsu_wdata = $urandom;
      end
      mif.mem_ready = ok && (k == w + 1);
      mif.mem_rdata = (k == w + 1) ? rd : $urandom;
      rst = (k == abort_at);
      exp_req   = (k >= 1) && (k <= busy);
      exp_we    = st;
      exp_addr  = {a[31:2], 2'b00};
      exp_wstrb = st ? s_strb : 4'b0000;
      exp_wdata = s_wd;
      exp_done  = (k == dk) && (abort_at < 0);
      exp_err   = !ok || to;
      exp_rdata = (ok && !to && ld) ? model_load(f3, a, rd) : 32'h0;
      exp_stall = (k < dk);
      chk_en = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    mif.mem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid = 0; lsu_load = 0; lsu_store = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    mif.mem_ready = 0; mif.mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset done", 32'(lsu_done), 32'h0);
    check("reset err", 32'(lsu_err), 32'h0);
    check("reset rdata", lsu_rdata, 32'h0);
    check("reset req", 32'(mif.mem_req), 32'h0);
    check("reset wstrb", 32'(mif.mem_wstrb), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // LW with ready in the first BUSY cycle
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, -1);
    check("LW addr", got_addr, 32'h100);
    check("LW we", 32'(got_we), 32'h0);
    check("LW wstrb", 32'(got_wstrb), 32'h0);
    check("LW rdata", got_rdata, 32'hDEADBEEF);
    check("LW done cycle", got_done_k, 2);

    // Load extraction from 0x80AABBCC
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 32'h80AABBCC, 1, -1);
    check("LB 0x103", got_rdata, 32'hFFFFFF80);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 32'h80AABBCC, 0, -1);
    check("LBU 0x103", got_rdata, 32'h00000080);
    do_op(1, 0, 3'b001, 32'h102, 32'h0, 32'h80AABBCC, 2, -1);
    check("LH 0x102", got_rdata, 32'hFFFF80AA);
    do_op(1, 0, 3'b101, 32'h100, 32'h0, 32'h80AABBCC, 0, -1);
    check("LHU 0x100", got_rdata, 32'h0000BBCC);
    do_op(1, 0, 3'b000, 32'h101, 32'h0, 32'h80AABBCC, 0, -1);
    check("LB 0x101", got_rdata, 32'hFFFFFFBB);

    // Store lanes with d = 0x12345678
    do_op(0, 1, 3'b000, 32'h201, 32'h12345678, 32'h0, 0, -1);
    check("SB addr", got_addr, 32'h200);
    check("SB wstrb", 32'(got_wstrb), 32'b0010);
    check("SB wdata", got_wdata, 32'h78787878);
    check("SB we", 32'(got_we), 32'h1);
    check("SB rdata", got_rdata, 32'h0);
    do_op(0, 1, 3'b001, 32'h202, 32'h12345678, 32'h0, 1, -1);
    check("SH wstrb", 32'(got_wstrb), 32'b1100);
    check("SH wdata", got_wdata, 32'h56785678);
    do_op(0, 1, 3'b010, 32'h204, 32'h12345678, 32'h0, 0, -1);
    check("SW wstrb", 32'(got_wstrb), 32'b1111);
    check("SW wdata", got_wdata, 32'h12345678);

    // Rejects: no memory request, done+err in cycle 1
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 32'h0, 0, -1);
    check("LW mis req", req_cycles, 0);
    check("LW mis done cycle", got_done_k, 1);
    check("LW mis err", 32'(got_err), 32'h1);
    check("LW mis rdata", got_rdata, 32'h0);
    do_op(0, 1, 3'b001, 32'h301, 32'hFFFF, 32'h0, 0, -1);
    check("SH mis req", req_cycles, 0);
    check("SH mis err", 32'(got_err), 32'h1);
    do_op(1, 0, 3'b011, 32'h100, 32'h0, 32'h0, 0, -1);
    check("LD f3=011 err", 32'(got_err), 32'h1);
    do_op(0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 0, -1);
    check("SBU err", 32'(got_err), 32'h1);
    do_op(1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 0, -1);
    check("load+store req", req_cycles, 0);

    // Timeout (TIMEOUT = 4) and ready on the last permitted cycle
    do_op(1, 0, 3'b010, 32'h400, 32'h0, 32'h11111111, 9, -1);
    check("timeout req cycles", req_cycles, 4);
    check("timeout err", 32'(got_err), 32'h1);
    check("timeout done cycle", got_done_k, 5);
    do_op(1, 0, 3'b010, 32'h400, 32'h0, 32'h22222222, 3, -1);
    check("ready@4 err", 32'(got_err), 32'h0);
    check("ready@4 rdata", got_rdata, 32'h22222222);

    // Reset in the 2nd BUSY cycle, then the held LW restarts
    do_op(1, 0, 3'b010, 32'h500, 32'h0, 32'h0, 10, 2);
    check("abort no done", got_done_k, -1);
    do_op(1, 0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 0, -1);
    check("restart rdata", got_rdata, 32'hCAFEF00D);
    check("restart done cycle", got_done_k, 2);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
